coeff_packer: RTL and testbench

- Upstream stage of the fixed-latency delay-line buffer in the homomorphic-encryption datapath.
- Accepts a stream of single polynomial coefficients over a valid/ready handshake.
- Packs them lane-by-lane into DATA_SIZE-bit words, then presents each word on a registered valid/ready output that feeds the delay line and the wide datapath behind it.
- Handles partial words at end-of-polynomial (s_last) and on explicit flush.

---
 rtl/coeff_packer.sv | 80 ++++++++
 tb/tb_coeff_packer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_packer.sv
// Packs a valid/ready stream of single coefficients into DATA_SIZE-bit words.
// The output register holds one word; partial words close on s_last or flush.
module coeff_packer #(
  parameter int COEFF_WIDTH = 64,
  parameter int DATA_SIZE   = 512
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [COEFF_WIDTH-1:0]               s_data,
  input  logic                                 s_last,
  input  logic                                 flush,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [DATA_SIZE-1:0]                 m_data,
  output logic [DATA_SIZE/COEFF_WIDTH-1:0]     m_keep,
  output logic                                 m_last
);

  localparam int LANES = DATA_SIZE / COEFF_WIDTH;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  if ((DATA_SIZE % COEFF_WIDTH) != 0 || DATA_SIZE < COEFF_WIDTH) begin : g_bad_cfg
    $fatal(1, "coeff_packer: DATA_SIZE must be a positive multiple of COEFF_WIDTH");
  end

  logic [LANES-1:0][COEFF_WIDTH-1:0] acc;
  logic [LANES-1:0][COEFF_WIDTH-1:0] word_next;
  logic [IDX_W-1:0]                  idx;
  logic [LANES-1:0]                  keep_next;
  logic                              accept;
  logic                              flush_take;
  logic                              complete;
  logic                              last_next;

  // The output slot is free when empty or being drained on this edge.
  assign s_ready    = !m_valid || m_ready;
  assign accept     = s_valid && s_ready;
  assign flush_take = flush && s_ready && ((idx != '0) || accept);
  assign complete   = (accept && ((idx == LAST_IDX) || s_last)) || flush_take;
  assign last_next  = accept && s_last;

  // NOTE: every variable in always_comb gets a default first; otherwise a latch is inferred.
  always_comb begin
    word_next = acc;
    keep_next = '0;
    if (accept) word_next[idx] = s_data;
    for (int i = 0; i < LANES; i++) begin
      keep_next[i] = (i < int'(idx)) || (accept && (i == int'(idx)));
    end
  end

  // NOTE: the accumulator is reset because unfilled lanes must read as zero in partial words.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc     <= '0;
      idx     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (complete) begin
      m_valid <= 1'b1;
      m_data  <= word_next;
      m_keep  <= keep_next;
      m_last  <= last_next;
      acc     <= '0;
      idx     <= '0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (accept) begin
        acc[idx] <= s_data;
        idx      <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_coeff_packer.sv
// Self-checking bench for coeff_packer: directed scenarios plus a random run,
// scored against a queue-based model of the packing rules.
module tb_coeff_packer;

  localparam int CW = 64;
  localparam int DS = 512;
  localparam int LN = DS / CW;

  typedef struct {
    logic [DS-1:0] data;
    logic [LN-1:0] keep;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [CW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DS-1:0] m_data;
  logic [LN-1:0] m_keep;
  logic          m_last;

  int n_vec = 0;
  int n_err = 0;

  logic [CW-1:0] pend[$];
  word_t         exp_q[$];
  logic          obs_sready;
  logic          obs_mvalid;

  coeff_packer #(.COEFF_WIDTH(CW), .DATA_SIZE(DS)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
    .m_last(m_last)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: close the pending coefficients into one expected word.
  task automatic emit(input logic last);
    word_t w;
    w.data = '0;
    for (int i = 0; i < pend.size(); i++) w.data[i*CW +: CW] = pend[i];
    w.keep = LN'((1 << pend.size()) - 1);
    w.last = last;
    exp_q.push_back(w);
    pend.delete();
  endtask

  // One clock cycle: drive at negedge, sample settled outputs, score transfers, update model.
  task automatic step(input logic sv, input logic [CW-1:0] d, input logic sl,
                      input logic fl, input logic mr);
    word_t w;
    logic  done;
    @(negedge clk);
    s_valid = sv; s_data = d; s_last = sl; flush = fl; m_ready = mr;
    #1;
    obs_sready = s_ready;
    obs_mvalid = m_valid;
    n_vec++;
    if (s_ready !== (!m_valid || mr)) begin
      n_err++;
      $display("FAIL s_ready: got %b want %b", s_ready, !m_valid || mr);
    end
    if (m_valid && mr) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got data=%h keep=%h last=%b, none expected",
                 m_data, m_keep, m_last);
      end else begin
        w = exp_q.pop_front();
        if (m_data !== w.data || m_keep !== w.keep || m_last !== w.last) begin
          n_err++;
          $display("FAIL word: got keep=%h last=%b data=%h want keep=%h last=%b data=%h",
                   m_keep, m_last, m_data, w.keep, w.last, w.data);
        end
      end
    end
    done = 1'b0;
    if (sv && s_ready) begin
      pend.push_back(d);
      if (pend.size() == LN || sl) begin
        emit(sl);
        done = 1'b1;
      end
    end
    if (!done && fl && s_ready && pend.size() > 0) emit(1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    do begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      k++;
    end while ((exp_q.size() > 0 || obs_mvalid) && k < 20);
    n_vec++;
    if (exp_q.size() != 0 || obs_mvalid) begin
      n_err++;
      $display("FAIL drain: got %0d words outstanding (m_valid=%b), want 0",
               exp_q.size(), obs_mvalid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_keep !== '0 || m_last !== 1'b0 || s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got v=%b keep=%h last=%b rdy=%b data=%h want all zero, rdy=1",
               m_valid, m_keep, m_last, s_ready, m_data);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_full_word();
    for (int i = 0; i < LN; i++) begin
      step(1'b1, CW'(i + 1), 1'b0, 1'b0, 1'b1);
      n_vec++;
      if (obs_sready !== 1'b1) begin
        n_err++;
        $display("FAIL full_word_sready: got %b want 1 at beat %0d", obs_sready, i);
      end
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (obs_mvalid !== 1'b1 || m_keep !== '1 || m_last !== 1'b0) begin
      n_err++;
      $display("FAIL full_word_latency: got v=%b keep=%h last=%b want v=1 keep=ff last=0",
               obs_mvalid, m_keep, m_last);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (obs_mvalid !== 1'b0) begin
      n_err++;
      $display("FAIL full_word_pulse: got m_valid=%b want 0", obs_mvalid);
    end
    drain();
  endtask

  task automatic test_last_partial();
    step(1'b1, CW'('hA), 1'b0, 1'b0, 1'b1);
    step(1'b1, CW'('hB), 1'b0, 1'b0, 1'b1);
    step(1'b1, CW'('hC), 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (obs_mvalid !== 1'b1 || m_keep !== LN'(8'h07) || m_last !== 1'b1) begin
      n_err++;
      $display("FAIL last_partial: got v=%b keep=%h last=%b want v=1 keep=07 last=1",
               obs_mvalid, m_keep, m_last);
    end
    for (int i = 0; i < LN; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    logic [DS-1:0] held;
    for (int i = 0; i < LN; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
      if (k == 0) held = m_data;
      n_vec++;
      if (obs_sready !== 1'b0 || obs_mvalid !== 1'b1 || m_data !== held) begin
        n_err++;
        $display("FAIL stall_%0d: got rdy=%b v=%b data_stable=%b want rdy=0 v=1 stable=1",
                 k, obs_sready, obs_mvalid, m_data === held);
      end
    end
    step(1'b1, CW'('h77), 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (obs_sready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: got s_ready=%b want 1", obs_sready);
    end
    for (int i = 1; i < LN; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 2 * LN + 2; k++) begin
      step(k <= 2 * LN, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
      n_vec++;
      if (obs_sready !== 1'b1 || obs_mvalid !== (k == LN + 1 || k == 2 * LN + 1)) begin
        n_err++;
        $display("FAIL back_to_back cycle %0d: got rdy=%b v=%b want rdy=1 v=%b",
                 k, obs_sready, obs_mvalid, k == LN + 1 || k == 2 * LN + 1);
      end
    end
    drain();
  endtask

  task automatic test_flush();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (obs_mvalid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_empty: got m_valid=%b want 0", obs_mvalid);
    end
    step(1'b1, CW'('h5), 1'b0, 1'b0, 1'b1);
    step(1'b1, CW'('h6), 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (obs_mvalid !== 1'b1 || m_keep !== LN'(8'h03) || m_last !== 1'b0) begin
      n_err++;
      $display("FAIL flush_partial: got v=%b keep=%h last=%b want v=1 keep=03 last=0",
               obs_mvalid, m_keep, m_last);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if (m_valid !== 1'b0 || m_data !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b data=%h want v=0 data=0", m_valid, m_data);
    end
    pend.delete();
    s_valid = 1'b0; s_last = 1'b0; flush = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < LN; i++) step(1'b1, CW'(16 + i), 1'b0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_last_partial();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
